// File: rtl/walk_request_register.sv
// Per-channel sticky pedestrian walk-request latch with an optional wait-age counter.
// Define WALK_REQ_AGE_EN to build the wr_age counters and port.
module walk_request_register #(
  parameter int NUM_REQ = 1,
  parameter int AGE_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       wr_sync,
  input  logic [NUM_REQ-1:0]       wr_reset,
  output logic [NUM_REQ-1:0]       wr,
  output logic                     wr_any
`ifdef WALK_REQ_AGE_EN
  ,
  output logic [NUM_REQ*AGE_W-1:0] wr_age
`endif
);

  // Clear wins over set, so a serve strobe always drops the request even
  // while the button is still held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= '0;
    end else begin
      wr <= (wr | wr_sync) & ~wr_reset;
    end
  end

  assign wr_any = |wr;

`ifdef WALK_REQ_AGE_EN
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
    logic [AGE_W-1:0] age;

    // Age looks at the registered request, so it reads 0 in the first
    // cycle the request is visible and saturates rather than wrapping.
    always_ff @(posedge clk) begin
      if (!rst_n || wr_reset[i] || !wr[i]) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + 1'b1;
      end
    end

    assign wr_age[i*AGE_W +: AGE_W] = age;
  end
`endif

endmodule

// File: tb/tb_walk_request_register.sv
// Scoreboard bench for walk_request_register (two channels, 3-bit age when WALK_REQ_AGE_EN is defined).
module tb_walk_request_register;
  localparam int N  = 2;
  localparam int AW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] wr_sync = '0;
  logic [N-1:0] wr_reset = '0;
  logic [N-1:0] wr;
  logic         wr_any;
`ifdef WALK_REQ_AGE_EN
  logic [N*AW-1:0] wr_age;
`endif

  // clock
  always #5 clk = ~clk;

  walk_request_register #(.NUM_REQ(N), .AGE_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_sync  (wr_sync),
    .wr_reset (wr_reset),
    .wr       (wr),
`ifdef WALK_REQ_AGE_EN
    .wr_any   (wr_any),
    .wr_age   (wr_age)
`else
    .wr_any   (wr_any)
`endif
  );

  // scoreboard: {age1, age0, wr_any, wr}
  logic [31:0]   exp_q[$];
  logic [N-1:0]  m_wr = '0;
  logic [AW-1:0] m_age[N];
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver: apply inputs for one edge, predict, then compare after the edge
  task automatic step(input logic r, input logic [N-1:0] s, input logic [N-1:0] c);
    logic [N-1:0]  nw;
    logic [AW-1:0] na[N];
    logic [31:0]   e;
    logic [31:0]   o;
    @(negedge clk);
    rst_n    = r;
    wr_sync  = s;
    wr_reset = c;
    for (int i = 0; i < N; i++) begin
      if (!r || c[i]) begin
        nw[i] = 1'b0;
        na[i] = '0;
      end else begin
        nw[i] = m_wr[i] | s[i];
        if (!m_wr[i])                 na[i] = '0;
        else if (m_age[i] == 3'd7)    na[i] = 3'd7;
        else                          na[i] = m_age[i] + 3'd1;
      end
    end
    m_wr = nw;
    for (int i = 0; i < N; i++) m_age[i] = na[i];
    exp_q.push_back({23'd0, na[1], na[0], |nw, nw});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("wr", 32'(wr), 32'(e[1:0]));
      check("wr_any", 32'(wr_any), 32'(e[2]));
`ifdef WALK_REQ_AGE_EN
      o = 32'(wr_age);
      check("wr_age", o, 32'(e[8:3]));
`else
      o = 32'd0;
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_age[i] = '0;
    // reset with button held, then release with button low
    step(1'b0, 2'b11, 2'b00);
    step(1'b1, 2'b00, 2'b00);
    // single pulse on channel 0, then hold 20 idle cycles (age saturates)
    step(1'b1, 2'b01, 2'b00);
    for (int k = 0; k < 20; k++) step(1'b1, 2'b00, 2'b00);
    // clear channel 0
    step(1'b1, 2'b00, 2'b01);
    for (int k = 0; k < 3; k++) step(1'b1, 2'b00, 2'b00);
    // simultaneous set and clear: clear wins, then set alone
    step(1'b1, 2'b01, 2'b01);
    step(1'b1, 2'b01, 2'b00);
    step(1'b1, 2'b00, 2'b00);
    // channel independence
    step(1'b1, 2'b00, 2'b11);
    step(1'b1, 2'b01, 2'b00);
    step(1'b1, 2'b00, 2'b10);
    step(1'b1, 2'b00, 2'b01);
    // age on channel 1 with button held 10 cycles, then clear
    for (int k = 0; k < 10; k++) step(1'b1, 2'b10, 2'b00);
    step(1'b1, 2'b00, 2'b10);
    step(1'b1, 2'b00, 2'b00);
    // reset mid-request
    step(1'b1, 2'b11, 2'b00);
    step(1'b1, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b00);
    step(1'b1, 2'b00, 2'b00);
    // random traffic
    for (int k = 0; k < 60; k++) begin
      logic [N-1:0] rs;
      logic [N-1:0] rc;
      rs = 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(($urandom_range(0, 30) != 0), rs, rc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
